// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg
//   Shared types and constants for the fetch-stage controller:
//   instruction address bus type, controller state encoding, stall
//   vector encodings and a word-alignment helper.
package fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned STALL_W     = 6;

    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [STALL_W-1:0]     stall_vec_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2,
        ST_PEND = 2'd3
    } fetch_state_e;

    // Stall vector bit order: [0] pc, [1] if, [2] id, [3] ex, [4] mem, [5] wb
    localparam stall_vec_t STALL_NONE = 6'b000000;
    localparam stall_vec_t STALL_MEM  = 6'b000011;
    localparam stall_vec_t STALL_ID   = 6'b000111;
    localparam stall_vec_t STALL_EX   = 6'b001111;

    // Redirect targets are always word aligned.
    function automatic inst_addr_bus_t align_addr(input inst_addr_bus_t addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Fetch-stage controller beside the PC register. Merges decode/execute
//   stall requests, instruction-memory wait states, branch redirects and
//   exception flushes into a 6-bit stall vector and a one-cycle PC
//   redirect command.
//
// Ports
//   clk, rst         core clock, synchronous active-high reset
//   stall_req_id     decode stall request (load-use)
//   stall_req_ex     execute stall request (multi-cycle op)
//   branch_flag      taken branch/jump resolved in decode this cycle
//   branch_addr      branch target
//   flush            exception flush from the memory stage
//   new_pc           exception handler address
//   imem_ack         instruction memory completes the current request
//   imem_req         fetch request / instruction-memory chip enable
//   stall            per-stage hold, [0] pc .. [5] wb
//   redir_en         PC register loads redir_addr at the next edge
//   redir_addr       redirect target, word aligned
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter inst_addr_bus_t RESET_VEC = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall_req_id,
    input  logic           stall_req_ex,
    input  logic           branch_flag,
    input  inst_addr_bus_t branch_addr,
    input  logic           flush,
    input  inst_addr_bus_t new_pc,
    input  logic           imem_ack,
    output logic           imem_req,
    output stall_vec_t     stall,
    output logic           redir_en,
    output inst_addr_bus_t redir_addr
);

    fetch_state_e   state_q, state_d;
    inst_addr_bus_t pend_addr_q, pend_addr_d;
    logic           pend_flush_q, pend_flush_d;

    stall_vec_t     stall_enc;
    logic           branch_ok;
    logic           redir_req;
    inst_addr_bus_t redir_tgt;
    logic           req_c;
    logic           redir_en_c;
    inst_addr_bus_t redir_addr_c;

    // Stall encoder: highest applicable entry wins, flush overrides all.
    always_comb begin
        stall_enc = STALL_NONE;
        if (flush) begin
            stall_enc = STALL_NONE;
        end else if (stall_req_ex) begin
            stall_enc = STALL_EX;
        end else if (stall_req_id) begin
            stall_enc = STALL_ID;
        end else if (state_q == ST_WAIT || state_q == ST_PEND) begin
            stall_enc = STALL_MEM;
        end
    end

    // A branch seen while decode is held is dropped; decode re-presents it.
    assign branch_ok = branch_flag & ~stall_enc[2];
    assign redir_req = flush | branch_ok;
    assign redir_tgt = flush ? new_pc : branch_addr;

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_flush_d = pend_flush_q;
        req_c        = 1'b0;
        redir_en_c   = 1'b0;
        redir_addr_c = '0;

        unique case (state_q)
            ST_BOOT: begin
                redir_en_c   = 1'b1;
                redir_addr_c = RESET_VEC;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                req_c = 1'b1;
                if (redir_req) begin
                    redir_en_c   = 1'b1;
                    redir_addr_c = redir_tgt;
                end
                state_d = imem_ack ? ST_RUN : ST_WAIT;
            end
            ST_WAIT: begin
                req_c = 1'b1;
                if (imem_ack) begin
                    // Ack in the same cycle: redirect directly, no PEND.
                    if (redir_req) begin
                        redir_en_c   = 1'b1;
                        redir_addr_c = redir_tgt;
                    end
                    state_d = ST_RUN;
                end else if (redir_req) begin
                    pend_addr_d  = redir_tgt;
                    pend_flush_d = flush;
                    state_d      = ST_PEND;
                end
            end
            ST_PEND: begin
                req_c = 1'b1;
                // A flush replaces any pending target; a branch may only
                // replace a pending branch.
                if (flush) begin
                    pend_addr_d  = new_pc;
                    pend_flush_d = 1'b1;
                end else if (branch_ok && !pend_flush_q) begin
                    pend_addr_d = branch_addr;
                end
                if (imem_ack) begin
                    redir_en_c   = 1'b1;
                    redir_addr_c = pend_addr_d;
                    pend_addr_d  = '0;
                    pend_flush_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Outputs are quiet while reset is held; a redirect cycle never stalls.
    always_comb begin
        imem_req   = 1'b0;
        stall      = STALL_NONE;
        redir_en   = 1'b0;
        redir_addr = '0;
        if (!rst) begin
            imem_req   = req_c;
            redir_en   = redir_en_c;
            redir_addr = redir_en_c ? align_addr(redir_addr_c) : '0;
            stall      = redir_en_c ? STALL_NONE : stall_enc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BOOT;
            pend_addr_q  <= '0;
            pend_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_flush_q <= pend_flush_d;
        end
    end

endmodule
